clock_switch_ctrl: RTL

Single-domain sequencer that drives the one-hot select of the glitch-free N-input clock mux. It accepts binary switch requests over a valid/ready handshake and monitors activity of every candidate clock. Switches run break-before-make with programmable settle gaps, so the mux's enable pipeline drains before the next source is selected. Requests to dead or out-of-range clocks are rejected with error pulses, which stops the mux from sticking on a stopped source.

---
 rtl/clock_switch_pkg.sv | 24 ++
 rtl/clock_switch_ctrl_if.sv | 13 +
 rtl/clk_activity_mon.sv | 62 ++++++
 rtl/clock_switch_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/clock_switch_pkg.sv
// Shared types and helpers for the clock-mux switch controller.
// Select indices are at most 4 bits wide because the mux tops out at 16 inputs.
package clock_switch_pkg;

    localparam int MAX_CLOCKS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_CLOCKS-1:0] onehot(input logic [3:0] index);
        logic [MAX_CLOCKS-1:0] v;
        v        = '0;
        v[index] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/clock_switch_ctrl_if.sv
// Switch-request handshake between a requester and the clock switch controller.
interface clock_switch_ctrl_if
    import clock_switch_pkg::*;
#(
    parameter int SEL_W = sel_width(3)
);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_sel;

    modport master (output req_valid, output req_sel, input req_ready);
    modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/clk_activity_mon.sv
// Per-source activity monitor: synchronises each divide-by-2 toggle, counts edges
// over a shared window and publishes a per-source alive flag at every window wrap.
module clk_activity_mon #(
    parameter int NUM_CLOCKS  = 3,
    parameter int ACT_WINDOW  = 64,
    parameter int MIN_TOGGLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CLOCKS-1:0] clk_toggle,
    output logic [NUM_CLOCKS-1:0] clk_alive
);
    localparam int WIN_W = $clog2(ACT_WINDOW);
    localparam int CNT_W = $clog2(MIN_TOGGLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ACT_WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MIN_TOGGLES);

    logic [NUM_CLOCKS-1:0] sync1_reg, sync2_reg, sync3_reg;
    logic [NUM_CLOCKS-1:0] edge_det;
    logic [WIN_W-1:0]      win_cnt_reg;
    logic                  win_wrap;

    assign edge_det = sync2_reg ^ sync3_reg;
    assign win_wrap = (win_cnt_reg == WIN_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            sync3_reg   <= '0;
            win_cnt_reg <= '0;
        end else begin
            sync1_reg   <= clk_toggle;
            sync2_reg   <= sync1_reg;
            sync3_reg   <= sync2_reg;
            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
            logic [CNT_W-1:0] edge_cnt_reg;
            logic             alive_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    edge_cnt_reg <= '0;
                    alive_reg    <= 1'b0;
                end else if (win_wrap) begin
                    alive_reg    <= (edge_cnt_reg >= CNT_SAT);
                    // An edge landing on the wrap cycle belongs to the new window.
                    edge_cnt_reg <= edge_det[gi] ? CNT_W'(1) : '0;
                end else if (edge_det[gi] && (edge_cnt_reg < CNT_SAT)) begin
                    edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
                end
            end

            assign clk_alive[gi] = alive_reg;
        end
    endgenerate

endmodule

// File: rtl/clock_switch_ctrl.sv
// Break-before-make sequencer driving the one-hot select of a glitch-free clock mux.
// Requests to dead or out-of-range sources are rejected with single-cycle error pulses.
module clock_switch_ctrl
    import clock_switch_pkg::*;
#(
    parameter  int NUM_CLOCKS    = 3,
    parameter  int ACT_WINDOW    = 64,
    parameter  int MIN_TOGGLES   = 2,
    parameter  int SETTLE_CYCLES = 16,
    parameter  int DEFAULT_SEL   = 0,
    localparam int SEL_W         = sel_width(NUM_CLOCKS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    clock_switch_ctrl_if.slave    req,
    input  logic [NUM_CLOCKS-1:0] clk_toggle,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic [NUM_CLOCKS-1:0] clk_alive,
    output logic                  err_dead,
    output logic                  err_invalid
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam int PAD_W = 2 ** SEL_W;
    localparam logic [CNT_W-1:0]      SETTLE_LAST    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W:0]        NUM_CLOCKS_W   = (SEL_W + 1)'(NUM_CLOCKS);
    localparam logic [SEL_W-1:0]      DEFAULT_IDX    = SEL_W'(DEFAULT_SEL);
    localparam logic [NUM_CLOCKS-1:0] DEFAULT_ONEHOT = NUM_CLOCKS'(onehot(4'(DEFAULT_SEL)));

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      settle_cnt_reg, settle_cnt_next;
    logic [SEL_W-1:0]      target_reg, target_next;
    logic [SEL_W-1:0]      cur_sel_reg, cur_sel_next;
    logic [NUM_CLOCKS-1:0] select_reg, select_next;
    logic                  err_dead_reg, err_dead_next;
    logic                  err_invalid_reg, err_invalid_next;
    logic [PAD_W-1:0]      alive_pad;
    logic                  accept, sel_invalid, settle_done, target_alive, abort;

    clk_activity_mon #(
        .NUM_CLOCKS  (NUM_CLOCKS),
        .ACT_WINDOW  (ACT_WINDOW),
        .MIN_TOGGLES (MIN_TOGGLES)
    ) u_activity_mon (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_toggle (clk_toggle),
        .clk_alive  (clk_alive)
    );

    // Padding lets any encodable req_sel index the alive vector safely.
    assign alive_pad    = PAD_W'(clk_alive);
    assign accept       = req.req_valid && (state_reg == IDLE);
    assign sel_invalid  = ({1'b0, req.req_sel} >= NUM_CLOCKS_W);
    assign settle_done  = (settle_cnt_reg == SETTLE_LAST);
    assign target_alive = alive_pad[target_reg];
    assign abort        = (state_reg == BREAK) && settle_done && !target_alive;

    always_comb begin
        state_next       = state_reg;
        settle_cnt_next  = settle_cnt_reg;
        target_next      = target_reg;
        cur_sel_next     = cur_sel_reg;
        select_next      = select_reg;
        err_dead_next    = 1'b0;
        err_invalid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (sel_invalid) begin
                        err_invalid_next = 1'b1;
                    end else if (req.req_sel != cur_sel_reg) begin
                        if (!alive_pad[req.req_sel]) begin
                            err_dead_next = 1'b1;
                        end else begin
                            target_next     = req.req_sel;
                            settle_cnt_next = '0;
                            select_next     = '0;
                            state_next      = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (settle_done) begin
                    settle_cnt_next = '0;
                    state_next      = MAKE;
                    // A target that died during the gap falls back to the old source.
                    if (target_alive) begin
                        cur_sel_next = target_reg;
                        select_next  = NUM_CLOCKS'(onehot(4'(target_reg)));
                    end else begin
                        select_next  = NUM_CLOCKS'(onehot(4'(cur_sel_reg)));
                    end
                end else begin
                    settle_cnt_next = settle_cnt_reg + CNT_W'(1);
                end
            end
            MAKE: begin
                if (settle_done) begin
                    settle_cnt_next = '0;
                    state_next      = IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            settle_cnt_reg  <= '0;
            target_reg      <= '0;
            cur_sel_reg     <= DEFAULT_IDX;
            select_reg      <= DEFAULT_ONEHOT;
            err_dead_reg    <= 1'b0;
            err_invalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            settle_cnt_reg  <= settle_cnt_next;
            target_reg      <= target_next;
            cur_sel_reg     <= cur_sel_next;
            select_reg      <= select_next;
            err_dead_reg    <= err_dead_next;
            err_invalid_reg <= err_invalid_next;
        end
    end

    assign req.req_ready = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign clk_select    = select_reg;
    assign cur_sel       = cur_sel_reg;
    assign err_dead      = err_dead_reg | abort;
    assign err_invalid   = err_invalid_reg;

endmodule
